o_drain_sram: RTL and testbench
===============================

// Module: o_drain_sram
// PURPOSE
// - Double-buffered output staging between the backend PE array and the memory controller.
// - Captures all NUM_ROWS PE output vectors in one parallel write when a row-block finishes.
// - Serialises them one row per handshake toward the memory controller for write-back.
// - While one bank drains, the other is free to accept the next block (ping-pong).
// PARAMETERS
// - NUM_ROWS  `NUM_PES  rows per bank, one per PE; any value >= 2, need not be a power of two
// - IDX_W     $clog2(NUM_ROWS)  width of the row index (derived; do not override)
// PORTS
// - clk         in   1                    clock
// - rst         in   1                    reset, synchronous, active-high
// - wr_valid    in   1                    backend presents a full block of NUM_ROWS vectors
// - wr_ready    out  1                    fill bank is empty and can take a block
// - wr_data     in   O_VECTOR_T[NUM_ROWS] PE outputs; index i comes from PE i
// - rd_valid    out  1                    drain bank holds a row for the memory controller
// - rd_ready    in   1                    memory controller accepts rd_data this cycle
// - rd_data     out  O_VECTOR_T           row rd_idx of the drain bank
// - rd_idx      out  IDX_W                row index of rd_data within its block
// - rd_last     out  1                    rd_valid && rd_idx == NUM_ROWS-1
// - occupancy   out  2                    number of full banks, 0..2
// BEHAVIOUR
// - State: bank0/bank1 arrays; fill_bank; drain_bank; full0/full1; rd_idx counter.
// - Reset values: fill_bank=0, drain_bank=0, full0=full1=0, rd_idx=0.
//   Outputs after reset: wr_ready=1, rd_valid=0, rd_last=0, occupancy=0.
//   Bank contents are not reset. rd_data is don't-care while rd_valid=0.
// - wr_ready = !full[fill_bank]. It is combinational from registered state only and never depends on wr_valid.
// - Write fire (wr_valid && wr_ready):
//   - all NUM_ROWS entries of wr_data go into bank[fill_bank] in one cycle;
//   - full[fill_bank] <= 1; fill_bank toggles.
// - wr_valid while !wr_ready: ignored. Nothing is stored and no state changes.
//   The backend must hold wr_data stable until it fires.
// - rd_valid = full[drain_bank]. rd_data = bank[drain_bank][rd_idx], combinational.
//   Read latency is 0 cycles from a full flag to data.
// - Read fire (rd_valid && rd_ready):
//   - if rd_idx == NUM_ROWS-1: rd_idx <= 0, full[drain_bank] <= 0, drain_bank toggles;
//   - else rd_idx <= rd_idx+1.
//   - Wrap uses an explicit compare, not bit overflow, so any NUM_ROWS works.
// - rd_ready while !rd_valid: ignored.
// - rd_valid is held with rd_data/rd_idx stable until the read fires (AXI-style; no withdrawal).
// - Timing:
//   - A block written in cycle N is readable in cycle N+1 (first rd_valid).
//   - It drains in NUM_ROWS read fires at minimum.
//   - A bank freed by its last read is writable the cycle after (no same-cycle bypass).
// - Simultaneous write fire + read fire: legal when fill_bank != drain_bank.
//   Each updates only its own bank's full flag; both take effect.
// - Both banks full: wr_ready=0 until the last-row read of drain_bank fires.
// - Both empty: fill_bank == drain_bank; rd_valid=0.
// - Ordering: blocks drain strictly in write order. Rows within a block drain 0..NUM_ROWS-1.
// - occupancy = full0 + full1.
// - Reset mid-drain: all flags and pointers return to their reset values; partial blocks are discarded. No output glitches beyond the reset cycle.
// STRUCTURE
// - Shared package, next to Q_VECTOR_T: O_VECTOR_T (output row type) and the `NUM_PES constant.
// - Single module; no sub-module. The bank arrays are plain registers, matching the input-side staging buffer.
// - Optional internal helper: a function next_idx(idx) that does the wrap compare.
// TESTING (NUM_ROWS=4; row i of block k = 16*k+i)
// - Reset -> wr_ready=1, rd_valid=0, occupancy=0.
//   Then rd_ready=1 for 3 cycles -> no state change.
// - Write block 0, rd_ready=1 always:
//   - rd_valid next cycle;
//   - rd_data 0,1,2,3 on 4 consecutive cycles;
//   - rd_last only on the row with value 3;
//   - then rd_valid=0.
// - Write blocks 0,1 back-to-back with rd_ready=0:
//   - occupancy=2 and wr_ready=0;
//   - a third wr_valid is ignored;
//   - drain gives 0..3 then 16..19;
//   - wr_ready rises the cycle after row 3 fires.
// - Write block 1 in the same cycle as reading row 2 of block 0 -> both take effect; the drain continues 2,3,16,17,18,19.
// - Random rd_ready (50%) and random wr_valid gaps over 200 blocks:
//   - the scoreboard sees every row exactly once, in order;
//   - rd_data is stable whenever rd_valid && !rd_ready.
// - Assert rst after 2 rows of block 0 drained -> next cycle rd_valid=0, occupancy=0, rd_idx=0, wr_ready=1.

Source files
------------

// File: rtl/o_drain_sram_pkg.sv
// Shared types and sizing for the PE-array input and output staging paths.
package o_drain_sram_pkg;

    localparam int NUM_PES = 4;
    localparam int Q_W     = 8;
    localparam int O_W     = 16;

    typedef logic [Q_W-1:0] Q_VECTOR_T;
    typedef logic [O_W-1:0] O_VECTOR_T;

endpackage

// File: rtl/o_drain_sram.sv
// Ping-pong output staging: captures a whole block of PE rows in one cycle and
// drains it one row per handshake toward the memory controller.
module o_drain_sram
    import o_drain_sram_pkg::*;
#(
    parameter int  NUM_ROWS = NUM_PES,
    localparam int IDX_W    = $clog2(NUM_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  O_VECTOR_T [NUM_ROWS-1:0] wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output O_VECTOR_T                rd_data,
    output logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_last,
    output logic [1:0]               occupancy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

    O_VECTOR_T [NUM_ROWS-1:0] bank0_r;
    O_VECTOR_T [NUM_ROWS-1:0] bank1_r;
    logic                     fill_bank_r;
    logic                     drain_bank_r;
    logic [1:0]               full_r;
    logic [IDX_W-1:0]         rd_idx_r;

    logic                     wr_fire_s;
    logic                     rd_fire_s;
    logic                     rd_wrap_s;
    logic [1:0]               full_set_s;
    logic [1:0]               full_clr_s;

    // Explicit compare so non-power-of-two row counts wrap correctly.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            next_idx = {IDX_W{1'b0}};
        end else begin
            next_idx = idx + IDX_W'(1);
        end
    endfunction

    // Handshake decode and read-side view, all from registered state.
    always_comb begin
        wr_ready   = ~full_r[fill_bank_r];
        rd_valid   = full_r[drain_bank_r];
        wr_fire_s  = wr_valid & wr_ready;
        rd_fire_s  = rd_valid & rd_ready;
        rd_wrap_s  = rd_fire_s & (rd_idx_r == LAST_IDX);
        full_set_s = wr_fire_s ? (2'b01 << fill_bank_r) : 2'b00;
        full_clr_s = rd_wrap_s ? (2'b01 << drain_bank_r) : 2'b00;
        rd_idx     = rd_idx_r;
        rd_last    = rd_valid & (rd_idx_r == LAST_IDX);
        occupancy  = {1'b0, full_r[0]} + {1'b0, full_r[1]};
        if (drain_bank_r) begin
            rd_data = bank1_r[rd_idx_r];
        end else begin
            rd_data = bank0_r[rd_idx_r];
        end
    end

    // Bank pointers, full flags and row counter; a write and a read never touch the same flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank_r  <= 1'b0;
            drain_bank_r <= 1'b0;
            full_r       <= 2'b00;
            rd_idx_r     <= {IDX_W{1'b0}};
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;
            if (wr_fire_s) begin
                fill_bank_r <= ~fill_bank_r;
            end
            if (rd_fire_s) begin
                rd_idx_r <= next_idx(rd_idx_r);
            end
            if (rd_wrap_s) begin
                drain_bank_r <= ~drain_bank_r;
            end
        end
    end

    // Block capture; bank contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s && !fill_bank_r) begin
            bank0_r <= wr_data;
        end
        if (wr_fire_s && fill_bank_r) begin
            bank1_r <= wr_data;
        end
    end

endmodule

// File: tb/tb_o_drain_sram.sv
// Bench for o_drain_sram: queue-of-blocks reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_o_drain_sram;
    import o_drain_sram_pkg::*;

    localparam int NR = NUM_PES;
    typedef O_VECTOR_T [NR-1:0] blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    blk_t        wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    O_VECTOR_T   rd_data;
    logic [1:0]  rd_idx;
    logic        rd_last;
    logic [1:0]  occupancy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rnd_phase = 1'b0;
    int seq = 0;

    blk_t mq[$];
    int   mhead = 0;

    o_drain_sram dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_idx    (rd_idx),
        .rd_last   (rd_last),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic blk_t blkval(input int k);
        blk_t b;
        for (int i = 0; i < NR; i++) b[i] = O_VECTOR_T'(16 * k + i);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of at most two captured blocks and a head-row cursor.
    initial begin
        forever begin
            int  sz;
            bit  wf, rf;
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mhead = 0;
            end else begin
                sz = mq.size();
                wf = wr_valid && (sz < 2);
                rf = rd_ready && (sz > 0);
                if (rf) begin
                    if (mhead == NR - 1) begin
                        void'(mq.pop_front());
                        mhead = 0;
                    end else begin
                        mhead++;
                    end
                end
                if (wf) mq.push_back(wr_data);
            end
        end
    end

    // Per-cycle comparison against the model, ordering scoreboard and hold-stability check.
    initial begin
        bit        prev_hold = 1'b0;
        O_VECTOR_T prev_data = '0;
        logic [1:0] prev_idx = '0;
        forever begin
            int sz;
            @(negedge clk);
            if (chk_en) begin
                sz = mq.size();
                check("m_wr_ready", wr_ready, (sz < 2) ? 1 : 0);
                check("m_rd_valid", rd_valid, (sz > 0) ? 1 : 0);
                check("m_occupancy", occupancy, sz);
                if (sz > 0) begin
                    check("m_rd_data", rd_data, mq[0][mhead]);
                    check("m_rd_idx", rd_idx, mhead);
                    check("m_rd_last", rd_last, (mhead == NR - 1) ? 1 : 0);
                end else begin
                    check("m_rd_last_idle", rd_last, 0);
                end
                if (prev_hold) begin
                    check("hold_data", rd_data, prev_data);
                    check("hold_idx", rd_idx, prev_idx);
                end
                if (rnd_phase && rd_valid && rd_ready) begin
                    check("order", rd_data, 16 * (100 + seq / NR) + seq % NR);
                    seq++;
                end
            end
            prev_hold = chk_en && !rst && rd_valid && !rd_ready;
            prev_data = rd_data;
            prev_idx  = rd_idx;
        end
    end

    initial begin
        int  kk;
        int  cyc;
        bit  fire;

        // Reset state, then rd_ready on an empty buffer must change nothing.
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_rd_last", rd_last, 0);
        rd_ready = 1'b1;
        repeat (3) step();
        check("idle_rd_valid", rd_valid, 0);
        check("idle_occupancy", occupancy, 0);
        check("idle_rd_idx", rd_idx, 0);
        check("idle_wr_ready", wr_ready, 1);

        // Single block with rd_ready held high.
        wr_data = blkval(0);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("b0_occupancy", occupancy, 1);
        for (int i = 0; i < NR; i++) begin
            check("b0_rd_valid", rd_valid, 1);
            check("b0_rd_data", rd_data, i);
            check("b0_rd_last", rd_last, (i == NR - 1) ? 1 : 0);
            step();
        end
        check("b0_done_valid", rd_valid, 0);

        // Two blocks back-to-back with no reads, then a third write is refused.
        rd_ready = 1'b0;
        wr_data = blkval(0);
        wr_valid = 1'b1;
        step();
        wr_data = blkval(1);
        step();
        wr_data = blkval(2);
        check("full_occupancy", occupancy, 2);
        check("full_wr_ready", wr_ready, 0);
        step();
        step();
        wr_valid = 1'b0;
        check("full_occ_after_ignored", occupancy, 2);
        rd_ready = 1'b1;
        for (int j = 0; j < 2 * NR; j++) begin
            check("pp_rd_data", rd_data, (j < NR) ? j : 16 + j - NR);
            check("pp_wr_ready", wr_ready, (j >= NR) ? 1 : 0);
            step();
        end
        check("pp_done_valid", rd_valid, 0);

        // Write block 1 in the same cycle row 2 of block 0 is read.
        rd_ready = 1'b0;
        wr_data = blkval(0);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        step();
        step();
        check("sim_row2", rd_data, 2);
        wr_data = blkval(1);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("sim_occupancy", occupancy, 2);
        check("sim_row3", rd_data, 3);
        step();
        for (int j = 0; j < NR; j++) begin
            check("sim_b1", rd_data, 16 + j);
            step();
        end
        check("sim_done_valid", rd_valid, 0);

        // Randomised traffic over 200 blocks.
        rnd_phase = 1'b1;
        kk = 0;
        cyc = 0;
        wr_data = blkval(100);
        wr_valid = 1'b1;
        while (kk < 200 && cyc < 20000) begin
            rd_ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            fire = wr_valid && wr_ready;
            step();
            cyc++;
            if (fire) begin
                kk++;
                wr_data = blkval(100 + kk);
                wr_valid = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            end else if (!wr_valid) begin
                wr_valid = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            end
        end
        wr_valid = 1'b0;
        check("rnd_blocks_written", kk, 200);
        rd_ready = 1'b1;
        for (int t = 0; t < 50 && rd_valid; t++) step();
        check("rnd_drain_done", rd_valid, 0);
        rnd_phase = 1'b0;
        check("rnd_rows_read", seq, 200 * NR);

        // Reset in the middle of a drain discards the partial block.
        rd_ready = 1'b0;
        wr_data = blkval(0);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        step();
        step();
        check("mid_row2", rd_data, 2);
        rst = 1'b1;
        rd_ready = 1'b0;
        step();
        check("mrst_rd_valid", rd_valid, 0);
        check("mrst_occupancy", occupancy, 0);
        check("mrst_rd_idx", rd_idx, 0);
        check("mrst_wr_ready", wr_ready, 1);
        rst = 1'b0;
        wr_data = blkval(5);
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("post_rst_row0", rd_data, 80);
        check("post_rst_idx", rd_idx, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
